// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC block: register map, register indices, CTRL bits
// and a byte-lane merge helper.
package rtc_pkg;

    localparam logic [4:0] MtimeLoOffset    = 5'h00;
    localparam logic [4:0] MtimeHiOffset    = 5'h04;
    localparam logic [4:0] MtimecmpLoOffset = 5'h08;
    localparam logic [4:0] MtimecmpHiOffset = 5'h0C;
    localparam logic [4:0] CtrlOffset       = 5'h10;
    localparam logic [4:0] PrescOffset      = 5'h14;

    typedef enum logic [2:0] {
        RegMtimeLo    = 3'd0,
        RegMtimeHi    = 3'd1,
        RegMtimecmpLo = 3'd2,
        RegMtimecmpHi = 3'd3,
        RegCtrl       = 3'd4,
        RegPresc      = 3'd5
    } rtc_reg_e;

    localparam int unsigned CtrlCntEnBit = 0;
    localparam int unsigned CtrlIrqEnBit = 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Tick divider for the RTC: emits one tick every (presc + 1) enabled cycles.
// Only instantiated when RTC_PRESCALER_EN is defined.
module rtc_prescaler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] presc,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == presc);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc.sv
// Memory-mapped 64-bit machine timer with compare interrupt.
// Optional tick prescaler is built only when RTC_PRESCALER_EN is defined.
module rtc
    import rtc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        mti_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mti_q, mti_d;

    logic [31:0] reg_rdata;
    logic [4:0]  word_addr;
    rtc_reg_e    reg_sel;
    logic        reg_hit;
    logic        wr, rd;
    logic        cnt_en, irq_en, tick;
    logic        unused_addr;

    assign word_addr   = {addr_i[4:2], 2'b00};
    assign unused_addr = ^addr_i[1:0];
    assign wr          = en_i && (we_i != 4'b0000);
    assign rd          = en_i && (we_i == 4'b0000);
    assign cnt_en      = ctrl_q[CtrlCntEnBit];
    assign irq_en      = ctrl_q[CtrlIrqEnBit];

    always_comb begin
        reg_sel = RegMtimeLo;
        reg_hit = 1'b1;
        case (word_addr)
            MtimeLoOffset:    reg_sel = RegMtimeLo;
            MtimeHiOffset:    reg_sel = RegMtimeHi;
            MtimecmpLoOffset: reg_sel = RegMtimecmpLo;
            MtimecmpHiOffset: reg_sel = RegMtimecmpHi;
            CtrlOffset:       reg_sel = RegCtrl;
            PrescOffset:      reg_sel = RegPresc;
            default:          reg_hit = 1'b0;
        endcase
    end

`ifdef RTC_PRESCALER_EN
    logic [15:0] presc_q, presc_d;
    logic        presc_wr;

    assign presc_wr = wr && reg_hit && (reg_sel == RegPresc);

    always_comb begin
        presc_d = presc_q;
        if (presc_wr) begin
            if (we_i[0]) presc_d[7:0]  = data_i[7:0];
            if (we_i[1]) presc_d[15:8] = data_i[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    rtc_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt_en),
        .presc   (presc_q),
        .clear   (presc_wr),
        .tick    (tick)
    );
`else
    assign tick = cnt_en;
`endif

    // A write to either mtime half replaces the increment; the other half is left as-is.
    always_comb begin
        mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        if (wr && reg_hit) begin
            case (reg_sel)
                RegMtimeLo:
                    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], data_i, we_i)};
                RegMtimeHi:
                    mtime_d = {merge_bytes(mtime_q[63:32], data_i, we_i), mtime_q[31:0]};
                RegMtimecmpLo:
                    mtimecmp_d = {mtimecmp_q[63:32],
                                  merge_bytes(mtimecmp_q[31:0], data_i, we_i)};
                RegMtimecmpHi:
                    mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], data_i, we_i),
                                  mtimecmp_q[31:0]};
                RegCtrl: begin
                    if (we_i[0]) ctrl_d = data_i[1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_hit) begin
            case (reg_sel)
                RegMtimeLo:    reg_rdata = mtime_q[31:0];
                RegMtimeHi:    reg_rdata = mtime_q[63:32];
                RegMtimecmpLo: reg_rdata = mtimecmp_q[31:0];
                RegMtimecmpHi: reg_rdata = mtimecmp_q[63:32];
                RegCtrl:       reg_rdata = {30'b0, ctrl_q};
`ifdef RTC_PRESCALER_EN
                RegPresc:      reg_rdata = {16'b0, presc_q};
`else
                RegPresc:      reg_rdata = '0;
`endif
                default:       reg_rdata = '0;
            endcase
        end
        rdata_d = rd ? reg_rdata : '0;
        mti_d   = irq_en && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            mti_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            mti_q      <= mti_d;
        end
    end

    assign data_o = rdata_q;
    assign mti_o  = mti_q;

endmodule

// File: tb/tb_rtc.sv
// Self-checking bench for rtc: table of static register accesses plus directed
// sequences for counting, carry, interrupt timing, prescaling and async reset.
`timescale 1ns/1ps
module tb_rtc;
    import rtc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [4:0]  addr_i = 5'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        mti_o;

    always #5 clk = ~clk;

    rtc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .mti_o   (mti_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        en_i = 1'b1; we_i = be; addr_i = a; data_i = d;
        @(negedge clk);
        en_i = 1'b0; we_i = 4'h0; data_i = 32'h0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        en_i = 1'b1; we_i = 4'h0; addr_i = a;
        @(negedge clk);
        en_i = 1'b0;
        d = data_o;
    endtask

    logic [31:0] rd;
    logic [31:0] presc_rd_exp;
    logic [31:0] d_cnt_exp;
    int          rise_at;

    initial begin
`ifdef RTC_PRESCALER_EN
        presc_rd_exp = 32'h3;
        d_cnt_exp    = 32'd10;
`else
        presc_rd_exp = 32'h0;
        d_cnt_exp    = 32'd40;
`endif
        repeat (3) @(negedge clk);
        check("rst_mti", {31'b0, mti_o}, 32'h0);
        check("rst_data", data_o, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Counting stays off throughout the table, so every read is static.
        vecs.push_back('{4'h0, MtimeLoOffset,    32'h0,        32'h0000_0000});
        vecs.push_back('{4'h0, MtimeHiOffset,    32'h0,        32'h0000_0000});
        vecs.push_back('{4'h0, MtimecmpLoOffset, 32'h0,        32'hFFFF_FFFF});
        vecs.push_back('{4'h0, MtimecmpHiOffset, 32'h0,        32'hFFFF_FFFF});
        vecs.push_back('{4'h0, CtrlOffset,       32'h0,        32'h0000_0000});
        vecs.push_back('{4'h0, PrescOffset,      32'h0,        32'h0000_0000});
        vecs.push_back('{4'hF, MtimeLoOffset,    32'h0000_1234, 32'h0});
        vecs.push_back('{4'h2, MtimeLoOffset,    32'h0000_AB00, 32'h0});
        vecs.push_back('{4'h0, MtimeLoOffset,    32'h0,        32'h0000_AB34});
        vecs.push_back('{4'h0, MtimeHiOffset,    32'h0,        32'h0000_0000});
        vecs.push_back('{4'h8, MtimecmpHiOffset, 32'h5A00_0000, 32'h0});
        vecs.push_back('{4'h0, MtimecmpHiOffset, 32'h0,        32'h5AFF_FFFF});
        vecs.push_back('{4'hF, CtrlOffset,       32'hFFFF_FFF2, 32'h0});
        vecs.push_back('{4'h0, CtrlOffset,       32'h0,        32'h0000_0002});
        vecs.push_back('{4'hF, 5'h18,            32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{4'h0, 5'h18,            32'h0,        32'h0000_0000});
        vecs.push_back('{4'h0, 5'h1C,            32'h0,        32'h0000_0000});
        vecs.push_back('{4'h3, PrescOffset,      32'hFFFF_0003, 32'h0});
        vecs.push_back('{4'h0, PrescOffset,      32'h0,        presc_rd_exp});
        vecs.push_back('{4'hF, PrescOffset,      32'h0,        32'h0});
        vecs.push_back('{4'hF, CtrlOffset,       32'h0,        32'h0});
        vecs.push_back('{4'h0, CtrlOffset,       32'h0,        32'h0000_0000});

        foreach (vecs[i]) begin
            if (vecs[i].we == 4'h0) begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end else begin
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].we);
            end
        end
        @(negedge clk);
        check("idle_data_zero", data_o, 32'h0);

        // Free-run for 100 cycles after enabling.
        bus_write(MtimeLoOffset, 32'h0, 4'hF);
        bus_write(MtimeHiOffset, 32'h0, 4'hF);
        bus_write(CtrlOffset, 32'h1, 4'hF);
        repeat (100) @(negedge clk);
        bus_read(MtimeLoOffset, rd);
        check("run100_lo", rd, 32'd100);
        bus_read(MtimeHiOffset, rd);
        check("run100_hi", rd, 32'h0);

        // Carry from low to high half across exactly three ticks.
        bus_write(CtrlOffset, 32'h0, 4'hF);
        bus_write(MtimeHiOffset, 32'h0, 4'hF);
        bus_write(MtimeLoOffset, 32'hFFFF_FFFE, 4'hF);
        bus_write(CtrlOffset, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        bus_write(CtrlOffset, 32'h0, 4'hF);
        bus_read(MtimeHiOffset, rd);
        check("carry_hi", rd, 32'h1);
        bus_read(MtimeLoOffset, rd);
        check("carry_lo", rd, 32'h1);

        // Write to HI while counting suppresses that cycle's increment.
        bus_write(CtrlOffset, 32'h1, 4'hF);
        bus_write(MtimeHiOffset, 32'h7, 4'hF);
        bus_write(CtrlOffset, 32'h0, 4'hF);
        bus_read(MtimeHiOffset, rd);
        check("prio_hi", rd, 32'h7);
        bus_read(MtimeLoOffset, rd);
        check("prio_lo", rd, 32'h2);

        // Compare interrupt timing.
        bus_write(MtimeLoOffset, 32'h0, 4'hF);
        bus_write(MtimeHiOffset, 32'h0, 4'hF);
        bus_write(MtimecmpHiOffset, 32'h0, 4'hF);
        bus_write(MtimecmpLoOffset, 32'd50, 4'hF);
        bus_write(CtrlOffset, 32'h3, 4'hF);
        rise_at = -1;
        for (int k = 1; k <= 200 && rise_at < 0; k++) begin
            if (mti_o) rise_at = k;
            else @(negedge clk);
        end
        check("mti_rise_cycle", rise_at, 32'd52);
        bus_write(MtimecmpLoOffset, 32'hFFFF_FFFF, 4'hF);
        check("mti_hold", {31'b0, mti_o}, 32'h1);
        @(negedge clk);
        check("mti_fall", {31'b0, mti_o}, 32'h0);
        bus_write(MtimecmpLoOffset, 32'h0, 4'hF);
        @(negedge clk);
        check("mti_cmp0", {31'b0, mti_o}, 32'h1);
        bus_write(CtrlOffset, 32'h1, 4'hF);
        @(negedge clk);
        check("mti_irq_off", {31'b0, mti_o}, 32'h0);
        bus_write(CtrlOffset, 32'h0, 4'hF);

        // 40 enabled cycles, with PRESC=3 when the prescaler is built.
        bus_write(MtimeLoOffset, 32'h0, 4'hF);
        bus_write(MtimeHiOffset, 32'h0, 4'hF);
        bus_write(PrescOffset, 32'h3, 4'hF);
        bus_write(CtrlOffset, 32'h1, 4'hF);
        repeat (39) @(negedge clk);
        bus_write(CtrlOffset, 32'h0, 4'hF);
        bus_read(MtimeLoOffset, rd);
        check("presc_count", rd, d_cnt_exp);
        bus_read(PrescOffset, rd);
        check("presc_read", rd, presc_rd_exp);

        // Asynchronous reset between clock edges while outputs are active.
        bus_write(CtrlOffset, 32'h3, 4'hF);
        repeat (2) @(negedge clk);
        check("pre_rst_mti", {31'b0, mti_o}, 32'h1);
        en_i = 1'b1; we_i = 4'h0; addr_i = CtrlOffset;
        @(posedge clk);
        #2;
        en_i = 1'b0;
        check("pre_rst_data", data_o, 32'h3);
        reset_n = 1'b0;
        #1;
        check("async_rst_data", data_o, 32'h0);
        check("async_rst_mti", {31'b0, mti_o}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(MtimecmpLoOffset, rd);
        check("post_rst_cmp_lo", rd, 32'hFFFF_FFFF);
        bus_read(MtimecmpHiOffset, rd);
        check("post_rst_cmp_hi", rd, 32'hFFFF_FFFF);
        bus_read(CtrlOffset, rd);
        check("post_rst_ctrl", rd, 32'h0);
        repeat (5) @(negedge clk);
        bus_read(MtimeLoOffset, rd);
        check("post_rst_no_count", rd, 32'h0);
        check("post_rst_mti", {31'b0, mti_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
